// File: rtl/ha_serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder that reuses a single half adder twice per bit.
// Latency 2*WIDTH+1 cycles from start to done; start is ignored while busy (no queueing).

module Half_Adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic ca
);
  assign sum = a ^ b;
  assign ca  = a & b;
endmodule

module ha_serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, P1, P2, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b, result, res_nxt;
  logic [IW-1:0]    idx;
  logic             carry, s1, c1;
  logic             ha_a, ha_b, ha_sum, ha_ca;
  logic             last_bit;

  Half_Adder u_ha (
    .a   (ha_a),
    .b   (ha_b),
    .sum (ha_sum),
    .ca  (ha_ca)
  );

  assign last_bit = (idx == IW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // P1 adds the operand bits; P2 folds the running carry into that partial sum.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    ha_a      = 1'b0;
    ha_b      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = P1;
      P1: begin
        busy      = 1'b1;
        ha_a      = op_a[idx];
        ha_b      = op_b[idx];
        state_nxt = P2;
      end
      P2: begin
        busy      = 1'b1;
        ha_a      = s1;
        ha_b      = carry;
        state_nxt = last_bit ? DONE : P1;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    res_nxt      = result;
    res_nxt[idx] = ha_sum;
  end

  // Outputs are loaded on the edge into DONE so they are valid alongside done.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      s1     <= 1'b0;
      c1     <= 1'b0;
      Sum    <= '0;
      Cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a   <= A;
            op_b   <= B;
            carry  <= Cin;
            idx    <= '0;
            result <= '0;
          end
        end
        P1: begin
          s1 <= ha_sum;
          c1 <= ha_ca;
        end
        P2: begin
          result <= res_nxt;
          carry  <= c1 | ha_ca;
          if (last_bit) begin
            Sum  <= res_nxt;
            Cout <= c1 | ha_ca;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/ha_serial_add_ctrl.md
HA_SERIAL_ADD_CTRL -- requirements
Module: ha_serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 Port: A  input  WIDTH  operand A; sampled in the start-accept cycle.
REQ-006 Port: B  input  WIDTH  operand B; sampled in the start-accept cycle.
REQ-007 Port: Cin  input  1  carry-in; sampled in the start-accept cycle.
REQ-008 Port: busy  output  1  high while an addition is in progress (states P1, P2).
REQ-009 Port: done  output  1  one-cycle pulse marking the cycle in which Sum/Cout become valid.
REQ-010 Port: Sum  output  WIDTH  registered result of A+B+Cin, modulo 2^WIDTH.
REQ-011 Port: Cout  output  1  registered carry-out of A+B+Cin.

Function
REQ-012 The block SHALL contain exactly one Half_Adder instance, time-multiplexed as the only addition datapath; no "+" operator on operand data.
REQ-013 FSM states SHALL be IDLE, P1, P2 and DONE.
REQ-014 IDLE: if start=1, latch A, B and Cin into internal operand and carry registers, clear bit index to 0, and go to P1; otherwise stay in IDLE.
REQ-015 P1: drive the half adder with A[i], B[i]; latch partial sum s1 and partial carry c1; go to P2.
REQ-016 P2: drive the half adder with s1 and the running carry; write HA Sum into result bit i; set carry <= c1 | HA Ca.
REQ-017 P2 transition: if i = WIDTH-1, go to DONE; otherwise increment i and go to P1.
REQ-018 DONE: load Sum from the result register and Cout from the final carry, assert done for this cycle only, then go to IDLE.
REQ-019 Latency: start accepted at edge T, so done=1 in cycle T+2*WIDTH+1 (T+17 for WIDTH=8); throughput is one addition per 2*WIDTH+2 cycles.
REQ-020 Sum and Cout SHALL hold their last value from the DONE cycle until the next DONE; they SHALL NOT change during P1 or P2.
REQ-021 busy SHALL be 1 exactly in P1 and P2; done SHALL be 1 exactly in DONE; busy and done SHALL never both be 1.
REQ-022 start during P1, P2 or DONE SHALL be ignored, with no queueing; changes on A, B or Cin after acceptance SHALL NOT affect the result.
REQ-023 start=1 in the IDLE cycle directly after DONE SHALL be accepted, giving back-to-back operation.
REQ-024 Overflow SHALL wrap modulo 2^WIDTH, with the carry reported only on Cout.

Reset
REQ-025 When rst=1 at an edge, the FSM SHALL go to IDLE; busy=0, done=0, Sum=0, Cout=0; internal operand, carry, index and partial registers cleared.
REQ-026 rst SHALL take priority over start and over any FSM transition, including mid-operation, and SHALL drop the in-flight addition without raising done.
REQ-027 The first start SHALL be accepted in the cycle after rst deasserts.

Verification (WIDTH=8)
REQ-028 A=0x5A, B=0x3C, Cin=0, start pulse at T -> busy=1 over T+1..T+16; done=1 at T+17 only; Sum=0x96, Cout=0.
REQ-029 A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1; then A=0xFF, B=0xFF, Cin=1 -> Sum=0xFF, Cout=1.
REQ-030 A=0x00, B=0x00, Cin=1 -> Sum=0x01, Cout=0; previous Sum/Cout held stable through T+1..T+16.
REQ-031 start re-pulsed at T+5 with A=0x11, B=0x22 while busy -> ignored; original result delivered at T+17; no second done.
REQ-032 rst asserted at T+8 mid-operation -> next cycle busy=0, done=0, Sum=0x00, Cout=0; no done; next start after rst completes normally.
REQ-033 start held high continuously with A=0x01, B=0x01 -> done pulses every 18 cycles with Sum=0x02 each time.
